// File: rtl/capture_pkg.sv
// Shared types and constants for the camera frame capture block.
package capture_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      CAPTURE  = 2'd2
   } state_t;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int LINE_W          = 16;

endpackage

// File: rtl/frame_capture_sync_edge.sv
// N-stage synchroniser for one camera control line, with
// single-clk rise/fall pulses taken off the last stage.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/frame_capture.sv
// DVP camera capture: synchronises the bus, packs bytes into
// pixel words and streams them into a frame buffer RAM.
module frame_capture
   import capture_pkg::*;
#(
   parameter logic VSYNC_ACTIVE    = 1'b0,
   parameter logic HREF_ACTIVE     = 1'b1,
   parameter int   DATA_W          = 8,
   parameter int   BYTES_PER_PIXEL = 2,
   parameter int   ADDR_W          = 17,
   parameter int   DEPTH           = 76800,
   parameter int   SYNC_STAGES     = SYNC_STAGES_DEF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        pixel_clk,
   input  logic                        vsync,
   input  logic                        hsync,
   input  logic [DATA_W-1:0]           data_in,
   input  logic                        arm,
   input  logic                        continuous,
   output logic [ADDR_W-1:0]           addr_out,
   output logic [DATA_W*BYTES_PER_PIXEL-1:0] data_out,
   output logic                        WE,
   output logic                        frame_done,
   output logic                        busy,
   output logic                        overflow,
   output logic [LINE_W-1:0]           line_count,
   output logic [ADDR_W-1:0]           pixel_count
);

   localparam int PIX_W = DATA_W * BYTES_PER_PIXEL;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [1:0] LAST_PH = 2'(BYTES_PER_PIXEL - 1);

   logic p_level, p_rise, p_fall;
   logic v_level, v_rise, v_fall;
   logic h_level, h_rise, h_fall;

   sync_edge #(.STAGES(SYNC_STAGES)) u_pclk (
      .clk(clk), .reset(reset), .d(pixel_clk),
      .level(p_level), .rise(p_rise), .fall(p_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES)) u_vsync (
      .clk(clk), .reset(reset), .d(vsync),
      .level(v_level), .rise(v_rise), .fall(v_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES)) u_href (
      .clk(clk), .reset(reset), .d(hsync),
      .level(h_level), .rise(h_rise), .fall(h_fall)
   );

   logic unused_sync;
   assign unused_sync = &{1'b0, p_level, p_fall, v_level};

   logic [DATA_W-1:0] dly_q [SYNC_STAGES];
   logic [DATA_W-1:0] dly_d [SYNC_STAGES];

   always_comb begin
      dly_d[0] = data_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         dly_d[i] = dly_q[i-1];
      end
   end

   logic sample, sof, eof, line_end;

   assign sample   = p_rise & (h_level == HREF_ACTIVE);
   assign sof      = VSYNC_ACTIVE ? v_fall : v_rise;
   assign eof      = VSYNC_ACTIVE ? v_rise : v_fall;
   assign line_end = HREF_ACTIVE ? h_fall : h_rise;

   state_t              state_q, state_d;
   logic [1:0]          phase_q, phase_d;
   logic [PIX_W-1:0]    shift_q, shift_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic                ovf_q, ovf_d;
   logic [ADDR_W-1:0]   pcnt_q, pcnt_d;
   logic                we_q, we_d;
   logic [PIX_W-1:0]    dout_q, dout_d;
   logic                done_q, done_d;

   logic [PIX_W-1:0]    word;
   logic [ADDR_W-1:0]   addr_eff;
   logic                full;

   // The address bump trails WE by one clk; look through it.
   assign addr_eff = addr_q + ADDR_W'(we_q);
   assign full     = ({1'b0, addr_eff} >= DEPTH_L);
   assign word     = (shift_q << DATA_W)
                   | PIX_W'(dly_q[SYNC_STAGES-1]);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      shift_d = shift_q;
      addr_d  = we_q ? addr_q + ADDR_W'(1) : addr_q;
      line_d  = line_q;
      ovf_d   = ovf_q;
      pcnt_d  = pcnt_q;
      we_d    = 1'b0;
      dout_d  = dout_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (arm) state_d = WAIT_SOF;
         end
         WAIT_SOF: begin
            if (sof) begin
               addr_d  = '0;
               line_d  = '0;
               ovf_d   = 1'b0;
               phase_d = '0;
               shift_d = '0;
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            if (sample) begin
               shift_d = word;
               if (phase_q == LAST_PH) begin
                  phase_d = '0;
                  if (full) begin
                     ovf_d = 1'b1;
                  end else begin
                     we_d   = 1'b1;
                     dout_d = word;
                  end
               end else begin
                  phase_d = phase_q + 2'd1;
               end
            end
            if (line_end) begin
               line_d  = line_q + LINE_W'(1);
               phase_d = '0;
            end
            if (eof) begin
               done_d  = 1'b1;
               pcnt_d  = addr_eff;
               state_d = continuous ? WAIT_SOF : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         phase_q <= '0;
         shift_q <= '0;
         addr_q  <= '0;
         line_q  <= '0;
         ovf_q   <= 1'b0;
         pcnt_q  <= '0;
         we_q    <= 1'b0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            dly_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         shift_q <= shift_d;
         addr_q  <= addr_d;
         line_q  <= line_d;
         ovf_q   <= ovf_d;
         pcnt_q  <= pcnt_d;
         we_q    <= we_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            dly_q[i] <= dly_d[i];
         end
      end
   end

   assign addr_out    = addr_q;
   assign data_out    = dout_q;
   assign WE          = we_q;
   assign frame_done  = done_q;
   assign busy        = (state_q != IDLE);
   assign overflow    = ovf_q;
   assign line_count  = line_q;
   assign pixel_count = pcnt_q;

endmodule

// File: tb/tb_frame_capture.sv
// Scoreboard bench for frame_capture: a default instance plus
// a DEPTH=4 instance sharing the same camera bus.
module tb_frame_capture;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       pixel_clk = 1'b0;
   logic       vsync = 1'b0;
   logic       hsync = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       arm = 1'b0;
   logic       arm_d = 1'b0;
   logic       continuous = 1'b0;

   logic [16:0] m_addr, d_addr, m_pcnt, d_pcnt;
   logic [15:0] m_data, d_data, m_line, d_line;
   logic        m_we, d_we, m_done, d_done;
   logic        m_busy, d_busy, m_ovf, d_ovf;

   frame_capture u_dut (
      .clk(clk), .reset(reset), .pixel_clk(pixel_clk),
      .vsync(vsync), .hsync(hsync), .data_in(data_in),
      .arm(arm), .continuous(continuous),
      .addr_out(m_addr), .data_out(m_data), .WE(m_we),
      .frame_done(m_done), .busy(m_busy), .overflow(m_ovf),
      .line_count(m_line), .pixel_count(m_pcnt)
   );

   frame_capture #(.DEPTH(4)) u_dep (
      .clk(clk), .reset(reset), .pixel_clk(pixel_clk),
      .vsync(vsync), .hsync(hsync), .data_in(data_in),
      .arm(arm_d), .continuous(1'b0),
      .addr_out(d_addr), .data_out(d_data), .WE(d_we),
      .frame_done(d_done), .busy(d_busy), .overflow(d_ovf),
      .line_count(d_line), .pixel_count(d_pcnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_miss = 0;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   logic [63:0] q_m[$];
   logic [63:0] q_d[$];
   int done_m = 0;
   int done_d = 0;
   int busy_drop = 0;
   bit watch_busy = 0;

   always @(negedge clk) begin
      logic [63:0] e;
      if (m_we) begin
         if (q_m.size() == 0) begin
            chk("m_we_unexpected", 64'd1, 64'd0);
         end else begin
            e = q_m.pop_front();
            chk("m_addr", 64'(m_addr), 64'(e[32:16]));
            chk("m_data", 64'(m_data), 64'(e[15:0]));
         end
      end
      if (d_we) begin
         if (q_d.size() == 0) begin
            chk("d_we_unexpected", 64'd1, 64'd0);
         end else begin
            e = q_d.pop_front();
            chk("d_addr", 64'(d_addr), 64'(e[32:16]));
            chk("d_data", 64'(d_data), 64'(e[15:0]));
         end
      end
      if (m_done) done_m++;
      if (d_done) done_d++;
      if (watch_busy && !m_busy) busy_drop++;
   end

   bit          exp_m = 0;
   bit          exp_d = 0;
   int          ea_m = 0;
   int          ea_d = 0;
   int          ph = 0;
   logic [15:0] w = '0;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick(1);
      arm = 1'b0;
      tick(2);
   endtask

   task automatic sof();
      vsync = 1'b1;
      ea_m = 0;
      ea_d = 0;
      tick(6);
   endtask

   task automatic eof();
      vsync = 1'b0;
      tick(10);
   endtask

   task automatic href_on();
      hsync = 1'b1;
      ph = 0;
      w = '0;
      tick(4);
   endtask

   task automatic href_off();
      hsync = 1'b0;
      tick(6);
   endtask

   task automatic bytes(input logic [7:0] start, input int n);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = start + 8'(i);
         data_in = b;
         pixel_clk = 1'b0;
         tick(4);
         pixel_clk = 1'b1;
         w = {w[7:0], b};
         ph++;
         if (ph == 2) begin
            ph = 0;
            if (exp_m) begin
               q_m.push_back({31'd0, 17'(ea_m), w});
               ea_m++;
            end
            if (exp_d && ea_d < 4) begin
               q_d.push_back({31'd0, 17'(ea_d), w});
               ea_d++;
            end
         end
         tick(4);
      end
   endtask

   task automatic line(input logic [7:0] start, input int n);
      href_on();
      bytes(start, n);
      href_off();
   endtask

   int d0;

   initial begin
      tick(3);
      chk("rst_addr", 64'(m_addr), 64'd0);
      chk("rst_busy", 64'(m_busy), 64'd0);
      reset = 1'b1;
      tick(3);
      chk("idle_we", 64'(m_we), 64'd0);
      chk("idle_line", 64'(m_line), 64'd0);
      chk("idle_pcnt", 64'(m_pcnt), 64'd0);
      chk("idle_ovf", 64'(m_ovf), 64'd0);

      // basic two-line frame
      exp_m = 1;
      pulse_arm();
      chk("armed_busy", 64'(m_busy), 64'd1);
      sof();
      line(8'h00, 8);
      line(8'h08, 8);
      eof();
      chk("t1_line", 64'(m_line), 64'd2);
      chk("t1_pcnt", 64'(m_pcnt), 64'd8);
      chk("t1_addr", 64'(m_addr), 64'd8);
      chk("t1_done", 64'(done_m), 64'd1);
      chk("t1_busy", 64'(m_busy), 64'd0);
      chk("t1_sb", 64'(q_m.size()), 64'd0);

      // arm in mid-frame: that frame is skipped
      d0 = done_m;
      exp_m = 0;
      sof();
      line(8'h80, 8);
      pulse_arm();
      line(8'h88, 8);
      eof();
      exp_m = 1;
      sof();
      line(8'h20, 8);
      eof();
      chk("t2_done", 64'(done_m - d0), 64'd1);
      chk("t2_pcnt", 64'(m_pcnt), 64'd4);
      chk("t2_sb", 64'(q_m.size()), 64'd0);

      // odd-length line drops its trailing byte
      pulse_arm();
      sof();
      line(8'h40, 7);
      line(8'h50, 4);
      eof();
      chk("t3_pcnt", 64'(m_pcnt), 64'd5);
      chk("t3_line", 64'(m_line), 64'd2);
      chk("t3_sb", 64'(q_m.size()), 64'd0);

      // depth limit on the DEPTH=4 instance
      exp_m = 0;
      exp_d = 1;
      arm_d = 1'b1;
      tick(1);
      arm_d = 1'b0;
      tick(2);
      sof();
      line(8'h70, 12);
      eof();
      chk("t4_ovf", 64'(d_ovf), 64'd1);
      chk("t4_addr", 64'(d_addr), 64'd4);
      chk("t4_pcnt", 64'(d_pcnt), 64'd4);
      chk("t4_sb", 64'(q_d.size()), 64'd0);
      arm_d = 1'b1;
      tick(1);
      arm_d = 1'b0;
      tick(2);
      sof();
      chk("t4_ovf_clr", 64'(d_ovf), 64'd0);
      line(8'h90, 2);
      eof();
      chk("t4_pcnt2", 64'(d_pcnt), 64'd1);
      chk("t4_done", 64'(done_d), 64'd2);
      exp_d = 0;

      // continuous mode, three frames
      d0 = done_m;
      exp_m = 1;
      continuous = 1'b1;
      pulse_arm();
      watch_busy = 1;
      for (int f = 0; f < 3; f++) begin
         sof();
         line(8'hA0 + 8'(4 * f), 4);
         if (f == 2) begin
            continuous = 1'b0;
            watch_busy = 0;
         end
         eof();
      end
      chk("t5_done", 64'(done_m - d0), 64'd3);
      chk("t5_busy_drop", 64'(busy_drop), 64'd0);
      chk("t5_idle", 64'(m_busy), 64'd0);
      chk("t5_pcnt", 64'(m_pcnt), 64'd2);
      chk("t5_sb", 64'(q_m.size()), 64'd0);

      // reset in the middle of a line
      pulse_arm();
      sof();
      href_on();
      bytes(8'h60, 3);
      chk("t6_pre_addr", 64'(m_addr), 64'd1);
      reset = 1'b0;
      #1;
      chk("t6_addr", 64'(m_addr), 64'd0);
      chk("t6_data", 64'(m_data), 64'd0);
      chk("t6_busy", 64'(m_busy), 64'd0);
      chk("t6_pcnt", 64'(m_pcnt), 64'd0);
      chk("t6_line", 64'(m_line), 64'd0);
      chk("t6_ovf", 64'(m_ovf), 64'd0);
      chk("t6_done", 64'(m_done), 64'd0);
      chk("t6_we", 64'(m_we), 64'd0);
      tick(1);
      reset = 1'b1;
      exp_m = 0;
      bytes(8'h63, 3);
      href_off();
      line(8'h66, 4);
      eof();
      sof();
      line(8'h6A, 4);
      eof();
      chk("t6_quiet_sb", 64'(q_m.size()), 64'd0);
      chk("t6_quiet_busy", 64'(m_busy), 64'd0);
      exp_m = 1;
      pulse_arm();
      sof();
      line(8'hB0, 4);
      eof();
      chk("t6_rearm_pcnt", 64'(m_pcnt), 64'd2);
      chk("t6_rearm_sb", 64'(q_m.size()), 64'd0);

      tick(5);
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_miss);
      $finish;
   end

endmodule
